replica_delay_monitor: RTL
==========================

// Module: replica_delay_monitor
// PURPOSE
//  Multi-channel, run-time tunable timing-error monitor for the error-resilient core. Each channel
//  launches a toggle every cycle into a replica inverter chain. The chain is sized to mirror one
//  pipeline stage's critical path (ALU, MUL, LSU addr).
//  The chain output is captured one cycle later, with a guard tap further down the chain.
//  Events are counted per observation window. An alarm req/ack handshake is raised to the
//  clock/voltage controller when a channel exceeds a threshold.
// PARAMETERS
//  NUM_CH      2     number of monitored paths / replica chains
//  MAX_STAGES  64    inverters per chain (even); taps selectable 2..MAX_STAGES
//  TAP_W       6     width of tap select, $clog2(MAX_STAGES)
//  GUARD       4     extra stages between main tap and guard tap (even)
//  CNT_W       12    per-channel event counter width (saturating)
//  WIN_W       16    observation window counter width
// PORTS
//  clk_i          in   1               core clock
//  rst_ni         in   1               async active-low reset
//  en_i           in   NUM_CH          per-channel monitor enable
//  tap_sel_i      in   NUM_CH*TAP_W    per-channel main tap (stage count); odd values use tap-1
//  win_len_i      in   WIN_W           window length in cycles (0 treated as 1)
//  thresh_i       in   CNT_W           alarm threshold, compare is count >= thresh_i (0 = never alarm)
//  err_inject_i   in   NUM_CH          test hook: inverts that channel's main capture this cycle
//  late_o         out  NUM_CH          1-cycle pulse: main tap missed capture edge
//  warn_o         out  NUM_CH          1-cycle pulse: guard tap missed (near-critical)
//  err_cnt_o      out  NUM_CH*CNT_W    late-event count of the last closed window
//  win_done_o     out  1               1-cycle pulse when a window closes
//  alarm_req_o    out  1               alarm request to DVFS controller (4-phase)
//  alarm_ch_o     out  NUM_CH          channels over threshold, stable while alarm_req_o=1
//  alarm_ack_i    in   1               controller acknowledge
// BEHAVIOUR
//  - Reset (async, rst_ni=0): all flops 0. Outputs late_o/warn_o/err_cnt_o/win_done_o/alarm_* = 0.
//    FSM=IDLE; window counter=0. Reset mid-handshake drops alarm_req_o immediately.
//  - Launch: per channel, launch_q toggles on every edge while en_i[c]=1 and holds when 0.
//  - Capture timing: launch edge E drives the chain. The main and guard taps are sampled at E+1.
//    Each sample is compared with launch_q as of E (tap parity even, so no polarity fix).
//    A mismatch registers late_o/warn_o high for the cycle after E+2 (latency 2).
//  - err_inject_i[c] at E+1 forces a main mismatch. It produces late_o[c] (not warn_o) after E+2.
//  - Blanking: for 2 cycles after en_i[c] rises or tap_sel_i[c] changes, channel c comparisons are
//    suppressed (no late/warn/count).
//  - Window: counter runs while any en_i=1 and wraps at win_len_i-1. In the terminal cycle,
//    win_done_o pulses on the next cycle.
//    err_cnt_o[c] = running count + that cycle's late event, saturating at 2^CNT_W-1.
//    The running count then clears. Disabled channels freeze their running count.
//    win_len_i changes take effect at the next window start.
//  - Alarm FSM: IDLE -> REQ when a window closes with any err_cnt >= thresh_i (thresh_i != 0).
//    Entering REQ latches alarm_ch_o.
//    REQ (alarm_req_o=1) -> ACKWAIT on alarm_ack_i=1. In ACKWAIT, req=0.
//    ACKWAIT -> IDLE on alarm_ack_i=0.
//    A window closing while not IDLE ORs its over-threshold mask into a pending register.
//    Pending non-zero in IDLE -> REQ next cycle with alarm_ch_o=pending, then pending clears.
//    alarm_ack_i in IDLE is ignored.
// STRUCTURE
//  - Shared package replica_pkg: ALARM state enum {IDLE, REQ, ACKWAIT}; BLANK_CYC=2; default tap
//    constants per path (ALU=28 derived from 3.394 ns critical / 0.1239 ns per inverter).
//  - Sub-module replica_delay_chain: one chain of MAX_STAGES inverter cells (dont_touch) with two
//    tap muxes (main, main+GUARD clamped to MAX_STAGES). Instantiated NUM_CH times.
//  - Top holds launch/capture flops, blanking, counters, window and alarm FSM.
// TESTING
//  - Reset: hold rst_ni=0, toggle en_i=2'b11 -> all outputs 0; release -> no late_o (zero-delay sim).
//  - Inject: en_i=1, tap=28, win_len=8, thresh=3; pulse err_inject_i[0] on 3 cycles in window ->
//    late_o[0] 3 pulses at +2, err_cnt_o[0]=3, alarm_req_o=1, alarm_ch_o=2'b01.
//  - Handshake: ack=1 -> req drops next cycle; hold ack=1 two windows over threshold -> req stays 0.
//    Drop ack -> req re-asserts once with pending mask.
//  - Blanking: change tap_sel_i[1] and inject same and next cycle -> no late_o[1]; inject at +2 ->
//    pulse.
//  - Saturation: CNT_W=4 build, inject every cycle with win_len=40 -> err_cnt_o=15, not 8.
//  - Boundary: inject on window terminal cycle -> counted in closing window; new window starts 0.

Source files
------------

// File: rtl/replica_pkg.sv
// Shared types and constants for the replica-path timing monitor.
package replica_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACKWAIT = 2'd2
  } alarm_state_e;

  localparam int BLANK_CYC = 2;

  // Default main taps: critical-path delay / 0.1239 ns per inverter, rounded up to an even count.
  localparam int TAP_ALU = 28;  // 3.394 ns
  localparam int TAP_MUL = 36;  // 4.400 ns
  localparam int TAP_LSU = 20;  // 2.410 ns

endpackage

// File: rtl/replica_delay_monitor_if.sv
// Alarm request/acknowledge channel between the timing monitor and the DVFS controller (4-phase).
interface replica_delay_monitor_if #(
  parameter int NUM_CH = 2
);
  logic              alarm_req_o;
  logic [NUM_CH-1:0] alarm_ch_o;
  logic              alarm_ack_i;

  modport master (output alarm_req_o, output alarm_ch_o, input alarm_ack_i);
  modport slave  (input alarm_req_o, input alarm_ch_o, output alarm_ack_i);
endinterface

// File: rtl/replica_delay_chain.sv
// One replica inverter chain with even-aligned main tap and a guard tap GUARD stages further.
// Purely combinational; both taps share the launch polarity because every tap index is even.
module replica_delay_chain #(
  parameter int MAX_STAGES = 64,
  parameter int TAP_W      = 6,
  parameter int GUARD      = 4,
  localparam int IDX_W     = $clog2(MAX_STAGES + 1)
) (
  input  logic             launch,
  input  logic [TAP_W-1:0] tap_sel,
  output logic             tap_main,
  output logic             tap_guard
);

  localparam logic [IDX_W-1:0] MIN_IDX   = IDX_W'(2);
  localparam logic [IDX_W-1:0] MAX_IDX   = IDX_W'(MAX_STAGES);
  localparam logic [IDX_W:0]   MAX_IDX_X = (IDX_W + 1)'(MAX_STAGES);
  localparam logic [IDX_W:0]   GUARD_X   = (IDX_W + 1)'(GUARD);

  (* dont_touch = "true" *) logic stage [MAX_STAGES + 1];

  logic [IDX_W-1:0] even_sel;
  logic [IDX_W-1:0] main_idx;
  logic [IDX_W:0]   guard_raw;
  logic [IDX_W-1:0] guard_idx;

  assign stage[0] = launch;
  for (genvar i = 1; i <= MAX_STAGES; i++) begin : g_inv
    assign stage[i] = ~stage[i-1];
  end

  // Odd selections fall back to the next lower even stage so no polarity fix is needed.
  assign even_sel  = IDX_W'(tap_sel) - IDX_W'(tap_sel[0]);
  assign main_idx  = (even_sel < MIN_IDX) ? MIN_IDX :
                     (even_sel > MAX_IDX) ? MAX_IDX : even_sel;
  assign guard_raw = {1'b0, main_idx} + GUARD_X;
  assign guard_idx = (guard_raw > MAX_IDX_X) ? MAX_IDX : guard_raw[IDX_W-1:0];

  assign tap_main  = stage[main_idx];
  assign tap_guard = stage[guard_idx];

endmodule

// File: rtl/replica_delay_monitor.sv
// Per-channel replica-path late/warn detection (latency 2), windowed late counts and a 4-phase alarm
// handshake; alarms raised while a handshake is busy are held in a pending mask, never dropped.
module replica_delay_monitor
  import replica_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int MAX_STAGES = 64,
  parameter int TAP_W      = 6,
  parameter int GUARD      = 4,
  parameter int CNT_W      = 12,
  parameter int WIN_W      = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH*TAP_W-1:0] tap_sel_i,
  input  logic [WIN_W-1:0]        win_len_i,
  input  logic [CNT_W-1:0]        thresh_i,
  input  logic [NUM_CH-1:0]       err_inject_i,
  output logic [NUM_CH-1:0]       late_o,
  output logic [NUM_CH-1:0]       warn_o,
  output logic [NUM_CH*CNT_W-1:0] err_cnt_o,
  output logic                    win_done_o,
  replica_delay_monitor_if.master alarm
);

  localparam logic [1:0] S_IDLE    = 2'(IDLE);
  localparam logic [1:0] S_REQ     = 2'(REQ);
  localparam logic [1:0] S_ACKWAIT = 2'(ACKWAIT);

  logic [NUM_CH-1:0] launch_q, en_q, tap_main, tap_guard;
  logic [NUM_CH-1:0] blank_trig, cmp_vld, evt_main, evt_guard;
  logic [NUM_CH-1:0] miss_main_q, miss_guard_q, over;
  logic [TAP_W-1:0]  tap_cur   [NUM_CH];
  logic [TAP_W-1:0]  tap_q     [NUM_CH];
  logic [1:0]        blank_cnt [NUM_CH];
  logic [CNT_W-1:0]  run_cnt   [NUM_CH];
  logic [CNT_W-1:0]  cnt_next  [NUM_CH];

  logic [WIN_W-1:0]  win_cnt, win_len_q, len_cur, len_eff;
  logic              win_run, win_term;

  logic [1:0]        state;
  logic [NUM_CH-1:0] pending, alarm_ch_q, over_close;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign tap_cur[c] = tap_sel_i[c*TAP_W +: TAP_W];

    replica_delay_chain #(
      .MAX_STAGES (MAX_STAGES),
      .TAP_W      (TAP_W),
      .GUARD      (GUARD)
    ) u_chain (
      .launch    (launch_q[c]),
      .tap_sel   (tap_cur[c]),
      .tap_main  (tap_main[c]),
      .tap_guard (tap_guard[c])
    );
  end

  // The compare sits in front of the capture flop so a late event belongs to the cycle whose
  // closing edge captures it; that keeps terminal-cycle events in the window that is closing.
  always_comb begin
    blank_trig = '0;
    cmp_vld    = '0;
    evt_main   = '0;
    evt_guard  = '0;
    over       = '0;
    cnt_next   = '{default: '0};
    for (int c = 0; c < NUM_CH; c++) begin
      blank_trig[c] = (en_i[c] & ~en_q[c]) | (tap_cur[c] != tap_q[c]);
      cmp_vld[c]    = en_i[c] & ~blank_trig[c] & (blank_cnt[c] == 2'd0);
      evt_main[c]   = cmp_vld[c] & ((tap_main[c] ^ err_inject_i[c]) != launch_q[c]);
      evt_guard[c]  = cmp_vld[c] & (tap_guard[c] != launch_q[c]);
      cnt_next[c]   = (&run_cnt[c]) ? run_cnt[c] : run_cnt[c] + CNT_W'(evt_main[c]);
      over[c]       = (thresh_i != '0) && (cnt_next[c] >= thresh_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      launch_q     <= '0;
      en_q         <= '0;
      miss_main_q  <= '0;
      miss_guard_q <= '0;
      late_o       <= '0;
      warn_o       <= '0;
      err_cnt_o    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        tap_q[c]     <= '0;
        blank_cnt[c] <= '0;
        run_cnt[c]   <= '0;
      end
    end else begin
      launch_q     <= launch_q ^ en_i;
      en_q         <= en_i;
      miss_main_q  <= evt_main;
      miss_guard_q <= evt_guard;
      late_o       <= miss_main_q;
      warn_o       <= miss_guard_q;
      for (int c = 0; c < NUM_CH; c++) begin
        tap_q[c] <= tap_cur[c];
        if (blank_trig[c]) begin
          blank_cnt[c] <= 2'(BLANK_CYC - 1);
        end else if (blank_cnt[c] != 2'd0) begin
          blank_cnt[c] <= blank_cnt[c] - 2'd1;
        end
        if (win_term) begin
          err_cnt_o[c*CNT_W +: CNT_W] <= cnt_next[c];
          run_cnt[c]                  <= '0;
        end else if (en_i[c]) begin
          run_cnt[c] <= cnt_next[c];
        end
      end
    end
  end

  // Window length is sampled in the first cycle of each window and held for the rest of it.
  assign win_run  = |en_i;
  assign len_cur  = (win_cnt == '0) ? win_len_i : win_len_q;
  assign len_eff  = (len_cur == '0) ? WIN_W'(1) : len_cur;
  assign win_term = win_run && (win_cnt == len_eff - WIN_W'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_cnt    <= '0;
      win_len_q  <= '0;
      win_done_o <= 1'b0;
    end else begin
      win_done_o <= win_term;
      if (win_run) begin
        if (win_cnt == '0) begin
          win_len_q <= win_len_i;
        end
        win_cnt <= win_term ? '0 : win_cnt + WIN_W'(1);
      end
    end
  end

  assign over_close = win_term ? over : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      pending    <= '0;
      alarm_ch_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if ((pending | over_close) != '0) begin
            state      <= S_REQ;
            alarm_ch_q <= pending | over_close;
            pending    <= '0;
          end
        end
        S_REQ: begin
          pending <= pending | over_close;
          if (alarm.alarm_ack_i) begin
            state <= S_ACKWAIT;
          end
        end
        S_ACKWAIT: begin
          pending <= pending | over_close;
          if (!alarm.alarm_ack_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign alarm.alarm_req_o = (state == S_REQ);
  assign alarm.alarm_ch_o  = alarm_ch_q;

endmodule
